// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : panel_pkg
// Description : Shared vending front-panel constants and operating-mode codes.
// Revision    : 1.0
// ============================================================================
package panel_pkg;

    localparam int MODE_W      = 2;
    localparam int N_ITEMS     = 8;
    localparam int TIMEOUT_CYC = 1000000;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE = 2'd0,
        MODE_INQ  = 2'd1,
        MODE_BUY  = 2'd2
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Registers a debounced button level and flags its rising edge.
// Revision    : 1.0
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= btn;
        end
    end

    assign ev = btn & ~r_q;

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mode_ctrl
// Description : Front-panel operating-mode sequencer (IDLE / INQ / BUY) with
//               item browsing and inactivity timeout.
// Revision    : 1.0
// ============================================================================
module mode_ctrl #(
    parameter int N_ITEMS     = panel_pkg::N_ITEMS,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT_CYC = panel_pkg::TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       btn_inq,
    input  logic                       btn_next,
    input  logic                       btn_buy,
    input  logic                       btn_back,
    input  logic                       buy_ack,
    output logic [panel_pkg::MODE_W-1:0] mode,
    output logic                       inquire_en,
    output logic [IDX_W-1:0]           item_idx,
    output logic                       buy_req,
    output logic                       timeout
);

    import panel_pkg::*;

    localparam int N_BTN = 4;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [N_BTN-1:0] w_btn;
    logic [N_BTN-1:0] w_ev;
    logic             w_any_ev;

    mode_e            r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_cnt_term;

    assign w_btn = {btn_back, btn_buy, btn_next, btn_inq};

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_edge u_btn_edge (
            .clk (clk),
            .rst (rst),
            .btn (w_btn[gi]),
            .ev  (w_ev[gi])
        );
    end

    assign w_any_ev   = |w_ev;
    assign w_cnt_term = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MODE_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Counter defaults to cleared; it only advances while a mode is held quietly.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = '0;
        w_timeout_nxt = 1'b0;
        if (!en) begin
            w_state_nxt = MODE_IDLE;
        end else begin
            case (r_state)
                MODE_IDLE: begin
                    if (w_ev[0]) begin
                        w_state_nxt = MODE_INQ;
                        w_idx_nxt   = '0;
                    end
                end
                MODE_INQ: begin
                    if (w_ev[3]) begin
                        w_state_nxt = MODE_IDLE;
                    end else if (w_ev[2]) begin
                        w_state_nxt = MODE_BUY;
                    end else if (w_ev[1]) begin
                        w_idx_nxt = (r_idx == IDX_W'(N_ITEMS - 1)) ? '0 : r_idx + 1'b1;
                    end
                end
                MODE_BUY: begin
                    if (buy_ack || w_ev[3]) begin
                        w_state_nxt = MODE_INQ;
                    end
                end
                default: w_state_nxt = MODE_IDLE;
            endcase

            if ((w_state_nxt == r_state) && (r_state != MODE_IDLE) && !w_any_ev) begin
                if (w_cnt_term) begin
                    w_state_nxt   = MODE_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    assign mode       = r_state;
    assign inquire_en = (r_state == MODE_INQ);
    assign buy_req    = (r_state == MODE_BUY);
    assign item_idx   = r_idx;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_ctrl
// Description : Self-checking bench for mode_ctrl (vector table, corner
//               sequences, randomized run against a reference model).
// Revision    : 1.0
// ============================================================================
module tb_mode_ctrl;

    localparam int N_ITEMS = 8;
    localparam int IDX_W   = 3;
    localparam int TMO     = 16;

    logic             clk = 1'b0;
    logic             rst, en, btn_inq, btn_next, btn_buy, btn_back, buy_ack;
    logic [1:0]       mode;
    logic             inquire_en, buy_req, timeout;
    logic [IDX_W-1:0] item_idx;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int     m_mode, m_idx, m_quiet;
    bit     m_to;
    bit [3:0] m_prev;

    always #5 clk = ~clk;

    mode_ctrl #(
        .N_ITEMS     (N_ITEMS),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_inq    (btn_inq),
        .btn_next   (btn_next),
        .btn_buy    (btn_buy),
        .btn_back   (btn_back),
        .buy_ack    (buy_ack),
        .mode       (mode),
        .inquire_en (inquire_en),
        .item_idx   (item_idx),
        .buy_req    (buy_req),
        .timeout    (timeout)
    );

    typedef struct packed {
        logic       rst, en, inq, nxt, buy, back, ack;
        logic [1:0] e_mode;
        logic [2:0] e_idx;
        logic       e_to;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input int r, e, i, n, b, k, a, em, ei, et);
        vec_t v;
        v.rst = 1'(r); v.en = 1'(e); v.inq = 1'(i); v.nxt = 1'(n);
        v.buy = 1'(b); v.back = 1'(k); v.ack = 1'(a);
        v.e_mode = 2'(em); v.e_idx = 3'(ei); v.e_to = 1'(et);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk_out(input string tag, input int em, input int ei, input int et);
        chk({tag, " mode"},       32'(mode),       32'(em));
        chk({tag, " inquire_en"}, 32'(inquire_en), 32'(em == 1));
        chk({tag, " buy_req"},    32'(buy_req),    32'(em == 2));
        chk({tag, " item_idx"},   32'(item_idx),   32'(ei));
        chk({tag, " timeout"},    32'(timeout),    32'(et));
    endtask

    // Behavioural model: buttons act on rising edges, quiet cycles are counted
    // while a mode is held, and the TMO-th quiet cycle returns to IDLE.
    task automatic model_step();
        bit [3:0] lv, ev;
        int       prev_mode;
        lv = {btn_back, btn_buy, btn_next, btn_inq};
        ev = lv & ~m_prev;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_quiet = 0; m_to = 0; m_prev = '0;
            return;
        end
        m_prev = lv;
        m_to   = 0;
        if (!en) begin
            m_mode = 0; m_quiet = 0;
            return;
        end
        prev_mode = m_mode;
        if (m_mode == 0) begin
            if (ev[0]) begin m_mode = 1; m_idx = 0; end
        end else if (m_mode == 1) begin
            if (ev[3])      m_mode = 0;
            else if (ev[2]) m_mode = 2;
            else if (ev[1]) m_idx = (m_idx + 1) % N_ITEMS;
        end else begin
            if (buy_ack || ev[3]) m_mode = 1;
        end
        if (m_mode != prev_mode || m_mode == 0 || ev != 0) begin
            m_quiet = 0;
        end else if (m_quiet == TMO - 1) begin
            m_mode = 0; m_to = 1; m_quiet = 0;
        end else begin
            m_quiet++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, m_mode, m_idx, int'(m_to));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1; en = 0; btn_inq = 0; btn_next = 0; btn_buy = 0; btn_back = 0; buy_ack = 0;
        m_mode = 0; m_idx = 0; m_quiet = 0; m_to = 0; m_prev = '0;

        //            rst en inq nxt buy bck ack  mode idx to
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0,   1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,   1, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 0, 0,   1, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,   1, 1, 0);
        tbl[6]  = mk(0, 1, 0, 1, 0, 0, 0,   1, 2, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0, 0, 0,   1, 2, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0,   1, 2, 0);
        tbl[9]  = mk(0, 1, 0, 0, 1, 0, 0,   2, 2, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0,   2, 2, 0);
        tbl[11] = mk(0, 1, 0, 1, 0, 0, 0,   2, 2, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 1,   1, 2, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 0,   1, 2, 0);
        tbl[14] = mk(0, 1, 0, 1, 1, 1, 0,   0, 2, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 0, 0,   0, 2, 0);
        tbl[16] = mk(0, 1, 0, 1, 0, 0, 0,   0, 2, 0);
        tbl[17] = mk(0, 1, 1, 0, 0, 0, 0,   1, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 1, 0, 0,   2, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 0, 1, 1,   1, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 0, 0, 0,   1, 0, 0);
        tbl[21] = mk(0, 1, 0, 0, 0, 1, 0,   0, 0, 0);
        tbl[22] = mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; btn_inq = tbl[i].inq; btn_next = tbl[i].nxt;
            btn_buy = tbl[i].buy; btn_back = tbl[i].back; buy_ack = tbl[i].ack;
            step();
            chk_out($sformatf("vec%0d", i), int'(tbl[i].e_mode), int'(tbl[i].e_idx), int'(tbl[i].e_to));
        end

        // Browse wrap: eight pulses step 1..7 then 0
        btn_inq = 1; step(); chk_out("enter_inq", 1, 0, 0); btn_inq = 0;
        for (int k = 0; k < 8; k++) begin
            btn_next = 1; step(); chk_out($sformatf("wrap%0d", k), 1, (k + 1) % N_ITEMS, 0);
            btn_next = 0; step();
        end
        // Held level gives one step only
        btn_next = 1;
        for (int k = 0; k < 5; k++) begin
            step(); chk_out($sformatf("hold%0d", k), 1, 1, 0);
        end
        btn_next = 0; step();

        // Purchase, held request, then ack
        btn_buy = 1; step(); chk_out("buy_enter", 2, 1, 0); btn_buy = 0;
        for (int k = 0; k < 3; k++) begin
            step(); chk_out($sformatf("buy_hold%0d", k), 2, 1, 0);
        end
        buy_ack = 1; step(); chk_out("buy_ack", 1, 1, 0); buy_ack = 0;

        // Inactivity timeout after 16 quiet cycles, pulse lasts one cycle
        for (int k = 0; k < TMO - 1; k++) begin
            step(); chk_out($sformatf("quiet%0d", k), 1, 1, 0);
        end
        step(); chk_out("timeout_hit", 0, 1, 1);
        step(); chk_out("timeout_drop", 0, 1, 0);

        // Event on the terminal cycle keeps INQ
        btn_inq = 1; step(); chk_out("reenter_inq", 1, 0, 0); btn_inq = 0;
        for (int k = 0; k < TMO - 1; k++) step();
        chk_out("pre_terminal", 1, 0, 0);
        btn_next = 1; step(); chk_out("terminal_event", 1, 1, 0);
        btn_next = 0; step(); chk_out("after_terminal", 1, 1, 0);

        // Enable drop during BUY
        btn_buy = 1; step(); chk_out("buy_b4_en", 2, 1, 0); btn_buy = 0;
        en = 0; step(); chk_out("en_low", 0, 1, 0);
        en = 1; step(); chk_out("en_back", 0, 1, 0);

        // Reset during BUY, then a stray ack
        btn_inq = 1; step(); btn_inq = 0;
        btn_buy = 1; step(); chk_out("buy_b4_rst", 2, 0, 0); btn_buy = 0;
        rst = 1; step(); chk_out("rst_in_buy", 0, 0, 0);
        rst = 0; buy_ack = 1; step(); chk_out("ack_after_rst", 0, 0, 0);
        buy_ack = 0; step(); chk_out("idle_after_rst", 0, 0, 0);

        // Randomized run against the reference model, alternating busy and quiet phases
        for (int c = 0; c < 800; c++) begin
            bit quiet;
            quiet   = ((c / 48) % 2) == 1;
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 49) != 0);
            if (!quiet) begin
                if ($urandom_range(0, 3) == 0) btn_inq  = ~btn_inq;
                if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
                if ($urandom_range(0, 4) == 0) btn_buy  = ~btn_buy;
                if ($urandom_range(0, 6) == 0) btn_back = ~btn_back;
                buy_ack = ($urandom_range(0, 9) == 0);
            end else begin
                buy_ack = ($urandom_range(0, 29) == 0);
            end
            step();
            chk_model($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
